// File: rtl/pkt_stream_pkg.sv
// Shared beat, drop-reason and write-FSM types for the packet ingress path.
package pkt_stream_pkg;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } pkt_beat_t;

  typedef enum logic [1:0] {
    DROP_NONE     = 2'd0,
    DROP_FULL     = 2'd1,
    DROP_OVERSIZE = 2'd2
  } drop_reason_t;

  typedef enum logic {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_t;

  function automatic pkt_beat_t pack_beat(input logic [63:0] data,
                                          input logic [7:0]  keep,
                                          input logic        last);
    pkt_beat_t b;
    b.data = data;
    b.keep = keep;
    b.last = last;
    return b;
  endfunction

endpackage

// File: rtl/pkt_buf_mem.sv
// Beat storage for the ingress buffer: simple dual-port array,
// synchronous write, asynchronous read (feeds the fall-through output).
module pkt_buf_mem
  import pkt_stream_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  pkt_beat_t     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output pkt_beat_t     rdata_o
);

  pkt_beat_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pkt_ingress_buffer.sv
// Store-and-forward packet FIFO: releases a packet only once its last beat is stored,
// dropping overflowing or oversize packets whole. Define PKT_BUF_STATS_EN for statistics counters.
module pkt_ingress_buffer
  import pkt_stream_pkg::*;
#(
  parameter int DEPTH         = 32,
  parameter int MAX_PKT_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid_i,
  input  logic [63:0]            s_data_i,
  input  logic [7:0]             s_keep_i,
  input  logic                   s_last_i,
  output logic                   s_ready_o,
  output logic                   m_valid_o,
  output logic [63:0]            m_data_o,
  output logic [7:0]             m_keep_o,
  output logic                   m_last_o,
  input  logic                   m_ready_i,
  output logic [$clog2(DEPTH):0] pkt_count_o,
  output logic                   drop_pulse_o,
  output drop_reason_t           drop_reason_o,
  output logic [31:0]            stat_rx_pkts_o,
  output logic [31:0]            stat_tx_pkts_o,
  output logic [31:0]            stat_drop_pkts_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);

  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_LEVEL   = PTR_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] OVERSIZE_CNT = CNT_W'(MAX_PKT_WORDS);

  wr_state_t        wr_state_q, wr_state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             ready_q;
  logic             drop_pulse_q;
  drop_reason_t     drop_reason_q, drop_reason_d;

  logic      beat_acc;
  logic      buf_full;
  logic      oversize;
  logic      mem_we;
  logic      commit;
  logic      drop_now;
  logic      rd_valid;
  logic      rd_fire;
  logic      rd_last;
  pkt_beat_t rd_beat;

  // Occupancy counts uncommitted beats too, so a growing packet can never overrun unread data.
  assign beat_acc = s_valid_i & ready_q;
  assign buf_full = (wr_ptr_q - rd_ptr_q) == FULL_LEVEL;
  assign oversize = (beat_cnt_q == OVERSIZE_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_ACCEPT;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_ACCEPT: begin
        if (beat_acc && (buf_full || oversize) && !s_last_i) begin
          wr_state_d = WR_DROP;
        end
      end
      WR_DROP: begin
        if (beat_acc && s_last_i) begin
          wr_state_d = WR_ACCEPT;
        end
      end
      default: wr_state_d = WR_ACCEPT;
    endcase
  end

  // Full takes priority over oversize; a drop rewinds to the last packet boundary.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    drop_reason_d = drop_reason_q;
    mem_we        = 1'b0;
    commit        = 1'b0;
    drop_now      = 1'b0;
    if ((wr_state_q == WR_ACCEPT) && beat_acc) begin
      if (buf_full || oversize) begin
        drop_now      = 1'b1;
        wr_ptr_d      = commit_ptr_q;
        beat_cnt_d    = '0;
        drop_reason_d = buf_full ? DROP_FULL : DROP_OVERSIZE;
      end else begin
        mem_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        beat_cnt_d = beat_cnt_q + CNT_ONE;
        if (s_last_i) begin
          commit       = 1'b1;
          commit_ptr_d = wr_ptr_q + PTR_ONE;
          beat_cnt_d   = '0;
        end
      end
    end
  end

  assign rd_valid = (rd_ptr_q != commit_ptr_q);
  assign rd_fire  = rd_valid & m_ready_i;
  assign rd_last  = rd_fire & rd_beat.last;

  always_comb begin
    rd_ptr_d    = rd_fire ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    pkt_count_d = pkt_count_q;
    case ({commit, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
      2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      rd_ptr_q      <= '0;
      pkt_count_q   <= '0;
      beat_cnt_q    <= '0;
      ready_q       <= 1'b0;
      drop_pulse_q  <= 1'b0;
      drop_reason_q <= DROP_NONE;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pkt_count_q   <= pkt_count_d;
      beat_cnt_q    <= beat_cnt_d;
      ready_q       <= 1'b1;
      drop_pulse_q  <= drop_now;
      drop_reason_q <= drop_reason_d;
    end
  end

  pkt_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (pack_beat(s_data_i, s_keep_i, s_last_i)),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_beat)
  );

  assign s_ready_o     = ready_q;
  assign m_valid_o     = rd_valid;
  assign m_data_o      = rd_beat.data;
  assign m_keep_o      = rd_beat.keep;
  assign m_last_o      = rd_beat.last;
  assign pkt_count_o   = pkt_count_q;
  assign drop_pulse_o  = drop_pulse_q;
  assign drop_reason_o = drop_reason_q;

`ifdef PKT_BUF_STATS_EN
  logic [31:0] stat_rx_q;
  logic [31:0] stat_tx_q;
  logic [31:0] stat_drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rx_q   <= '0;
      stat_tx_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      if (commit)   stat_rx_q   <= stat_rx_q + 32'd1;
      if (rd_last)  stat_tx_q   <= stat_tx_q + 32'd1;
      if (drop_now) stat_drop_q <= stat_drop_q + 32'd1;
    end
  end

  assign stat_rx_pkts_o   = stat_rx_q;
  assign stat_tx_pkts_o   = stat_tx_q;
  assign stat_drop_pkts_o = stat_drop_q;
`else
  assign stat_rx_pkts_o   = '0;
  assign stat_tx_pkts_o   = '0;
  assign stat_drop_pkts_o = '0;
`endif

  // A stalled output beat must hold steady until the inspector takes it.
  assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable({m_data_o, m_keep_o, m_last_o})));

  assert property (@(posedge clk) disable iff (!rst_n)
    mem_we |-> !buf_full);

endmodule

// File: tb/tb_pkt_ingress_buffer.sv
// Directed bench for pkt_ingress_buffer: latency, full/oversize drops,
// commit-vs-read pkt_count interplay, mid-packet reset and statistics.
module tb_pkt_ingress_buffer;
  import pkt_stream_pkg::*;

  localparam int DEPTH = 32;
  localparam int MAX_PKT_WORDS = 16;
  localparam int CW = $clog2(DEPTH) + 1;

`ifdef PKT_BUF_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sValid = 1'b0;
  logic [63:0]   sData = '0;
  logic [7:0]    sKeep = '0;
  logic          sLast = 1'b0;
  logic          sReady;
  logic          mValid;
  logic [63:0]   mData;
  logic [7:0]    mKeep;
  logic          mLast;
  logic          mReady = 1'b0;
  logic [CW-1:0] pktCount;
  logic          dropPulse;
  drop_reason_t  dropReason;
  logic [31:0]   statRx, statTx, statDrop;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pkt_ingress_buffer #(
    .DEPTH         (DEPTH),
    .MAX_PKT_WORDS (MAX_PKT_WORDS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_valid_i        (sValid),
    .s_data_i         (sData),
    .s_keep_i         (sKeep),
    .s_last_i         (sLast),
    .s_ready_o        (sReady),
    .m_valid_o        (mValid),
    .m_data_o         (mData),
    .m_keep_o         (mKeep),
    .m_last_o         (mLast),
    .m_ready_i        (mReady),
    .pkt_count_o      (pktCount),
    .drop_pulse_o     (dropPulse),
    .drop_reason_o    (dropReason),
    .stat_rx_pkts_o   (statRx),
    .stat_tx_pkts_o   (statTx),
    .stat_drop_pkts_o (statDrop)
  );

  function automatic logic [63:0] beatData(input int pkt, input int beat);
    logic [15:0] p, b;
    p = pkt[15:0];
    b = beat[15:0];
    return {16'hC0DE, p, b, 16'hBEEF ^ b};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs read there are stable since the last rising edge.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic r);
    @(negedge clk);
    sValid = v;
    sData  = d;
    sKeep  = k;
    sLast  = l;
    mReady = r;
  endtask

  task automatic expectBeat(input string tag, input logic [63:0] d, input logic [7:0] k, input logic l);
    checkOutput({tag, ".valid"}, mValid, 1'b1);
    checkOutput({tag, ".data"}, mData, d);
    checkOutput({tag, ".keep"}, mKeep, k);
    checkOutput({tag, ".last"}, mLast, l);
  endtask

  task automatic checkStats(input string tag, input int rx, input int tx, input int drop);
    checkOutput({tag, ".rx"}, statRx, STATS_EN ? rx : 0);
    checkOutput({tag, ".tx"}, statTx, STATS_EN ? tx : 0);
    checkOutput({tag, ".drop"}, statDrop, STATS_EN ? drop : 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    checkOutput("rst.s_ready", sReady, 1'b0);
    checkOutput("rst.m_valid", mValid, 1'b0);
    checkOutput("rst.pkt_count", pktCount, 0);
    checkOutput("rst.drop_pulse", dropPulse, 1'b0);
    checkOutput("rst.drop_reason", dropReason, DROP_NONE);
    checkStats("rst", 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst.ready_still_low", sReady, 1'b0);

    // Test 1: 3-beat packet, fall-through one cycle after the last beat
    $display("[TB] test 1: basic 3-beat packet");
    applyStimulus(1'b1, beatData(1, 0), 8'hFF, 1'b0, 1'b1);
    checkOutput("t1.s_ready", sReady, 1'b1);
    checkOutput("t1.mvalid0", mValid, 1'b0);
    checkOutput("t1.cnt0", pktCount, 0);
    applyStimulus(1'b1, beatData(1, 1), 8'hFF, 1'b0, 1'b1);
    checkOutput("t1.mvalid1", mValid, 1'b0);
    applyStimulus(1'b1, beatData(1, 2), 8'h0F, 1'b1, 1'b1);
    checkOutput("t1.mvalid2", mValid, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t1.b0", beatData(1, 0), 8'hFF, 1'b0);
    checkOutput("t1.cnt1", pktCount, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t1.b1", beatData(1, 1), 8'hFF, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t1.b2", beatData(1, 2), 8'h0F, 1'b1);
    checkOutput("t1.cnt_before_last", pktCount, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t1.mvalid_end", mValid, 1'b0);
    checkOutput("t1.cnt_end", pktCount, 0);

    // Test 2: fill with four 8-beat packets, fifth is dropped as DROP_FULL
    $display("[TB] test 2: buffer full drop");
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 8; b++) begin
        applyStimulus(1'b1, beatData(20 + p, b), 8'hFF, b == 7, 1'b0);
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("t2.cnt_full", pktCount, 4);
    expectBeat("t2.head", beatData(20, 0), 8'hFF, 1'b0);
    for (int b = 0; b < 8; b++) begin
      applyStimulus(1'b1, beatData(24, b), 8'hFF, b == 7, 1'b0);
      checkOutput($sformatf("t2.drop_pulse.b%0d", b), dropPulse, b == 1);
      checkOutput($sformatf("t2.drop_reason.b%0d", b), dropReason, (b >= 1) ? DROP_FULL : DROP_NONE);
      checkOutput($sformatf("t2.cnt.b%0d", b), pktCount, 4);
      checkOutput($sformatf("t2.head_stable.b%0d", b), mData, beatData(20, 0));
    end
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 8; b++) begin
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        expectBeat($sformatf("t2.p%0d.b%0d", p, b), beatData(20 + p, b), 8'hFF, b == 7);
        checkOutput($sformatf("t2.cnt.p%0d.b%0d", p, b), pktCount, 4 - p);
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t2.mvalid_end", mValid, 1'b0);
    checkOutput("t2.cnt_end", pktCount, 0);
    checkOutput("t2.reason_held", dropReason, DROP_FULL);

    // Test 3: 17-beat packet dropped as oversize, next packet intact
    $display("[TB] test 3: oversize drop");
    for (int b = 0; b < 17; b++) begin
      applyStimulus(1'b1, beatData(30, b), 8'hFF, b == 16, 1'b1);
      checkOutput($sformatf("t3.mvalid.b%0d", b), mValid, 1'b0);
      checkOutput($sformatf("t3.drop_pulse.b%0d", b), dropPulse, 1'b0);
    end
    applyStimulus(1'b1, beatData(31, 0), 8'hFF, 1'b0, 1'b1);
    checkOutput("t3.drop_pulse", dropPulse, 1'b1);
    checkOutput("t3.drop_reason", dropReason, DROP_OVERSIZE);
    checkOutput("t3.mvalid_after_drop", mValid, 1'b0);
    applyStimulus(1'b1, beatData(31, 1), 8'h03, 1'b1, 1'b1);
    checkOutput("t3.drop_pulse_gone", dropPulse, 1'b0);
    checkOutput("t3.reason_held", dropReason, DROP_OVERSIZE);
    checkOutput("t3.mvalid_pending", mValid, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t3.n0", beatData(31, 0), 8'hFF, 1'b0);
    checkOutput("t3.cnt", pktCount, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t3.n1", beatData(31, 1), 8'h03, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t3.mvalid_end", mValid, 1'b0);
    checkOutput("t3.cnt_end", pktCount, 0);

    // Test 4: commit of Q coincides with read of P's last beat, m_ready toggling
    $display("[TB] test 4: simultaneous commit and last-beat read");
    applyStimulus(1'b1, beatData(40, 0), 8'hFF, 1'b0, 1'b0);
    checkOutput("t4.mvalid0", mValid, 1'b0);
    applyStimulus(1'b1, beatData(40, 1), 8'h7F, 1'b1, 1'b0);
    applyStimulus(1'b1, beatData(41, 0), 8'hFF, 1'b0, 1'b1);
    expectBeat("t4.p0", beatData(40, 0), 8'hFF, 1'b0);
    checkOutput("t4.cnt_a", pktCount, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    expectBeat("t4.p1_stall", beatData(40, 1), 8'h7F, 1'b1);
    applyStimulus(1'b1, beatData(41, 1), 8'h3F, 1'b1, 1'b1);
    expectBeat("t4.p1_read", beatData(40, 1), 8'h7F, 1'b1);
    checkOutput("t4.cnt_b", pktCount, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    expectBeat("t4.q0_stall", beatData(41, 0), 8'hFF, 1'b0);
    checkOutput("t4.cnt_unchanged", pktCount, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t4.q0_read", beatData(41, 0), 8'hFF, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    expectBeat("t4.q1_stall", beatData(41, 1), 8'h3F, 1'b1);
    checkOutput("t4.cnt_c", pktCount, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t4.q1_read", beatData(41, 1), 8'h3F, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("t4.mvalid_end", mValid, 1'b0);
    checkOutput("t4.cnt_end", pktCount, 0);
    checkStats("t4.stats", 8, 8, 2);

    // Test 5: reset mid-packet with one committed packet outstanding
    $display("[TB] test 5: reset mid-packet");
    applyStimulus(1'b1, beatData(50, 0), 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, beatData(50, 1), 8'hFF, 1'b1, 1'b0);
    applyStimulus(1'b1, beatData(51, 0), 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, beatData(51, 1), 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("t5.cnt_pre", pktCount, 1);
    expectBeat("t5.head_pre", beatData(50, 0), 8'hFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5.mvalid_rst", mValid, 1'b0);
    checkOutput("t5.cnt_rst", pktCount, 0);
    checkOutput("t5.sready_rst", sReady, 1'b0);
    checkOutput("t5.reason_rst", dropReason, DROP_NONE);
    checkStats("t5.stats_rst", 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, beatData(52, 0), 8'hFF, 1'b0, 1'b1);
    checkOutput("t5.sready_back", sReady, 1'b1);
    checkOutput("t5.mvalid0", mValid, 1'b0);
    applyStimulus(1'b1, beatData(52, 1), 8'hFF, 1'b0, 1'b1);
    checkOutput("t5.mvalid1", mValid, 1'b0);
    applyStimulus(1'b1, beatData(52, 2), 8'h01, 1'b1, 1'b1);
    checkOutput("t5.mvalid2", mValid, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t5.b0", beatData(52, 0), 8'hFF, 1'b0);
    checkOutput("t5.cnt1", pktCount, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t5.b1", beatData(52, 1), 8'hFF, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    expectBeat("t5.b2", beatData(52, 2), 8'h01, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t5.mvalid_end", mValid, 1'b0);
    checkOutput("t5.cnt_end", pktCount, 0);
    checkStats("t5.stats_end", 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
